// File: rtl/conv_sched_pkg.sv
// conv_sched shared types: FSM states, instruction field map,
// idle instruction word and the packer from fields to a 34-bit word.
package conv_sched_pkg;

  localparam int AW = 11;
  localparam int INST_W = 34;

  localparam int INST_ACC      = 33;
  localparam int INST_CEN_P    = 32;
  localparam int INST_WEN_P    = 31;
  localparam int INST_AP_LSB   = 20;
  localparam int INST_CEN_X    = 19;
  localparam int INST_WEN_X    = 18;
  localparam int INST_AX_LSB   = 7;
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_RELU     = 5;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_L0_RD    = 3;
  localparam int INST_L0_WR    = 2;
  localparam int INST_EXEC     = 1;
  localparam int INST_LOAD     = 0;

  localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WLOAD,
    S_WFLUSH,
    S_EXEC,
    S_EDRAIN,
    S_ACC_CLR,
    S_ACC_RD,
    S_ACC_LAST,
    S_ACC_OUT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic          acc;
    logic          cen_p;
    logic          wen_p;
    logic [AW-1:0] a_p;
    logic          cen_x;
    logic          wen_x;
    logic [AW-1:0] a_x;
    logic          ofifo_rd;
    logic          relu;
    logic          ififo_rd;
    logic          l0_rd;
    logic          l0_wr;
    logic          execute;
    logic          load;
  } inst_f_t;

  function automatic logic [INST_W-1:0] pack_inst(
    input inst_f_t f
  );
    logic [INST_W-1:0] w;
    w = '0;
    w[INST_ACC]              = f.acc;
    w[INST_CEN_P]            = f.cen_p;
    w[INST_WEN_P]            = f.wen_p;
    w[INST_AP_LSB +: AW]     = f.a_p;
    w[INST_CEN_X]            = f.cen_x;
    w[INST_WEN_X]            = f.wen_x;
    w[INST_AX_LSB +: AW]     = f.a_x;
    w[INST_OFIFO_RD]         = f.ofifo_rd;
    w[INST_RELU]             = f.relu;
    w[INST_IFIFO_RD]         = f.ififo_rd;
    w[INST_L0_RD]            = f.l0_rd;
    w[INST_L0_WR]            = f.l0_wr;
    w[INST_EXEC]             = f.execute;
    w[INST_LOAD]             = f.load;
    return w;
  endfunction

endpackage

// File: rtl/conv_acc_addr_gen.sv
// Accumulation-pass pmem address: kij*len_nij + (orow+ki)*IN_W + ocol+kj.
// Ports: clear (new run), kclr/kstep (kernel walk), pstep (next pixel), addr.
module conv_acc_addr_gen
  import conv_sched_pkg::*;
#(
  parameter int IN_W  = 6,
  parameter int K     = 3,
  parameter int OUT_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          kclr,
  input  logic          kstep,
  input  logic          pstep,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] NIJ    = AW'(IN_W * IN_W);
  localparam logic [AW-1:0] ROW_W  = AW'(IN_W);
  localparam logic [3:0]    K_END  = 4'(K - 1);
  localparam logic [3:0]    OW_END = 4'(OUT_W - 1);

  // kb = kij*len_nij, kr = ki*IN_W, row_b = orow*IN_W
  logic [3:0]    kj;
  logic [3:0]    ocol;
  logic [AW-1:0] kb;
  logic [AW-1:0] kr;
  logic [AW-1:0] row_b;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      kj    <= '0;
      ocol  <= '0;
      kb    <= '0;
      kr    <= '0;
      row_b <= '0;
    end else begin
      if (kclr) begin
        kj <= '0;
        kr <= '0;
        kb <= '0;
      end else if (kstep) begin
        kb <= kb + NIJ;
        if (kj == K_END) begin
          kj <= '0;
          kr <= kr + ROW_W;
        end else begin
          kj <= kj + 4'd1;
        end
      end
      if (pstep) begin
        if (ocol == OW_END) begin
          ocol  <= '0;
          row_b <= row_b + ROW_W;
        end else begin
          ocol <= ocol + 4'd1;
        end
      end
    end
  end

  assign addr = kb + kr + row_b
              + {7'd0, kj} + {7'd0, ocol};

endmodule

// File: rtl/conv_sched.sv
// 3x3 conv tile sequencer: weight load, execute, psum capture, accumulation.
// Ports: start/relu/ofifo_valid in; inst, acc_clr, out_valid, busy, done out.
// CONV_SCHED_PERF_EN adds perf_cycles/perf_stalls counters.
module conv_sched
  import conv_sched_pkg::*;
#(
  parameter int          ROW       = 8,
  parameter int          COL       = 8,
  parameter int          IN_W      = 6,
  parameter int          K         = 3,
  parameter int          OUT_W     = 4,
  parameter logic [10:0] WBASE     = 11'h400,
  parameter int          FLUSH_CYC = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              relu,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              acc_clr,
  output logic              out_valid,
  output logic              busy,
`ifdef CONV_SCHED_PERF_EN
  output logic [31:0]       perf_cycles,
  output logic [15:0]       perf_stalls,
`endif
  output logic              done
);

  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int LEN_KIJ  = K * K;
  localparam int LEN_ONIJ = OUT_W * OUT_W;

  localparam logic [7:0] T_COL    = 8'(COL);
  localparam logic [7:0] T_ROW    = 8'(ROW);
  localparam logic [7:0] T_NIJ    = 8'(LEN_NIJ);
  localparam logic [7:0] T_WL_END = 8'(COL + ROW - 1);
  localparam logic [7:0] T_FL_END = 8'(FLUSH_CYC - 1);
  localparam logic [7:0] T_EX_END = 8'(LEN_NIJ + 1);
  localparam logic [7:0] T_RD_END = 8'(LEN_KIJ - 1);

  localparam logic [AW-1:0] A_NIJ = AW'(LEN_NIJ);
  localparam logic [AW-1:0] A_COL = AW'(COL);

  localparam logic [3:0] KIJ_END  = 4'(LEN_KIJ - 1);
  localparam logic [4:0] ONIJ_END = 5'(LEN_ONIJ - 1);

  state_t        state, state_n;
  logic [7:0]    t, t_n;
  logic [3:0]    kij, kij_n;
  logic [4:0]    onij, onij_n;
  logic [AW-1:0] wcnt, wcnt_n;
  logic [AW-1:0] pbase, pbase_n;
  logic [AW-1:0] wbase, wbase_n;

  logic    acc_clr_n, out_valid_n;
  logic    busy_n, done_n;
  logic    cap;
  inst_f_t f;

  logic          ag_clr, ag_kclr;
  logic          ag_kstep, ag_pstep;
  logic [AW-1:0] ag_addr;

  conv_acc_addr_gen #(
    .IN_W  (IN_W),
    .K     (K),
    .OUT_W (OUT_W)
  ) u_ag (
    .clk   (clk),
    .reset (reset),
    .clear (ag_clr),
    .kclr  (ag_kclr),
    .kstep (ag_kstep),
    .pstep (ag_pstep),
    .addr  (ag_addr)
  );

  // psum capture is live in EXEC and EDRAIN until all len_nij rows land
  assign cap = ofifo_valid && (wcnt < A_NIJ)
            && (state == S_EXEC || state == S_EDRAIN);

  always_comb begin
    state_n     = state;
    t_n         = t;
    kij_n       = kij;
    onij_n      = onij;
    wcnt_n      = wcnt;
    pbase_n     = pbase;
    wbase_n     = wbase;
    acc_clr_n   = 1'b0;
    out_valid_n = 1'b0;
    done_n      = 1'b0;
    busy_n      = busy;
    ag_clr      = 1'b0;
    ag_kclr     = 1'b0;
    ag_kstep    = 1'b0;
    ag_pstep    = 1'b0;
    f           = '0;
    f.cen_p     = 1'b1;
    f.wen_p     = 1'b1;
    f.cen_x     = 1'b1;
    f.wen_x     = 1'b1;

    unique case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          state_n = S_WLOAD;
          t_n     = '0;
          kij_n   = '0;
          onij_n  = '0;
          wcnt_n  = '0;
          pbase_n = '0;
          wbase_n = WBASE;
          busy_n  = 1'b1;
          ag_clr  = 1'b1;
        end
      end
      S_WLOAD: begin
        t_n = t + 8'd1;
        if (t < T_COL) begin
          f.cen_x = 1'b0;
          f.a_x   = wbase + {3'd0, t};
        end
        if (t >= 8'd1 && t <= T_COL) f.l0_wr = 1'b1;
        if (t >= 8'd1) begin
          f.l0_rd = 1'b1;
          f.load  = 1'b1;
        end
        if (t == T_WL_END) begin
          state_n = S_WFLUSH;
          t_n     = '0;
        end
      end
      S_WFLUSH: begin
        t_n = t + 8'd1;
        if (t < T_ROW) f.l0_rd = 1'b1;
        if (t == T_FL_END) begin
          state_n = S_EXEC;
          t_n     = '0;
        end
      end
      S_EXEC: begin
        t_n = t + 8'd1;
        if (t < T_NIJ) begin
          f.cen_x = 1'b0;
          f.a_x   = {3'd0, t};
        end
        if (t >= 8'd1 && t <= T_NIJ) f.l0_wr = 1'b1;
        if (t >= 8'd2) begin
          f.l0_rd   = 1'b1;
          f.execute = 1'b1;
        end
        if (t == T_EX_END) begin
          state_n = S_EDRAIN;
          t_n     = '0;
        end
      end
      S_EDRAIN: begin
        if (wcnt < A_NIJ) begin
          f.l0_rd   = 1'b1;
          f.execute = 1'b1;
        end else begin
          kij_n   = kij + 4'd1;
          pbase_n = pbase + A_NIJ;
          wbase_n = wbase + A_COL;
          wcnt_n  = '0;
          state_n = (kij == KIJ_END) ? S_ACC_CLR : S_WLOAD;
        end
      end
      S_ACC_CLR: begin
        acc_clr_n = 1'b1;
        ag_kclr   = 1'b1;
        t_n       = '0;
        state_n   = S_ACC_RD;
      end
      S_ACC_RD: begin
        f.cen_p  = 1'b0;
        f.wen_p  = 1'b1;
        f.a_p    = ag_addr;
        // pmem data arrives one cycle after the first read
        f.acc    = (t != 8'd0);
        f.relu   = relu;
        ag_kstep = 1'b1;
        t_n      = t + 8'd1;
        if (t == T_RD_END) state_n = S_ACC_LAST;
      end
      S_ACC_LAST: begin
        f.acc   = 1'b1;
        f.relu  = relu;
        state_n = S_ACC_OUT;
      end
      S_ACC_OUT: begin
        out_valid_n = 1'b1;
        ag_pstep    = 1'b1;
        onij_n      = onij + 5'd1;
        state_n     = (onij == ONIJ_END) ? S_DONE : S_ACC_CLR;
      end
      S_DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (cap) begin
      f.ofifo_rd = 1'b1;
      f.cen_p    = 1'b0;
      f.wen_p    = 1'b0;
      f.a_p      = pbase + wcnt;
      wcnt_n     = wcnt + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      t         <= '0;
      kij       <= '0;
      onij      <= '0;
      wcnt      <= '0;
      pbase     <= '0;
      wbase     <= '0;
      inst      <= INST_IDLE;
      acc_clr   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      t         <= t_n;
      kij       <= kij_n;
      onij      <= onij_n;
      wcnt      <= wcnt_n;
      pbase     <= pbase_n;
      wbase     <= wbase_n;
      inst      <= pack_inst(f);
      acc_clr   <= acc_clr_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

`ifdef CONV_SCHED_PERF_EN
  // counts every non-idle cycle, i.e. exactly the cycles busy is high
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        perf_cycles <= '0;
        perf_stalls <= '0;
      end
    end else begin
      perf_cycles <= perf_cycles + 32'd1;
      if (state == S_EDRAIN && !ofifo_valid)
        perf_stalls <= perf_stalls + 16'd1;
    end
  end
`endif

endmodule
